// File: rtl/idct_dezigzag_feeder.sv
// Dequantize and de-zigzag JPEG coefficients into ping-pong 8x8 banks, drained as row beats.
// Define IDCT_FEED_DEQUANT_EN to build in the quant table and multiplier.
module idct_dezigzag_feeder #(
    parameter int WCOEF = 12,
    parameter int WQ    = 8,
    parameter int WIN   = 12
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WCOEF-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    input  logic             q_we,
    input  logic [5:0]       q_addr,
    input  logic [WQ-1:0]    q_data,
    output logic [WIN*8-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             err_len
);
    localparam int PW = WCOEF + WQ + 1;
    localparam logic signed [PW-1:0] SAT_HI = PW'((2 ** (WIN - 1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-(2 ** (WIN - 1)));
    localparam logic [5:0] ZZ_ROM [64] = '{
        0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [WIN-1:0] bank_q [2][64];
    logic [WIN-1:0] bank_d [2][64];
    logic [63:0]    mask_q [2];
    logic [63:0]    mask_d [2];
    logic [1:0]     full_q, full_d;
    logic           wb_q, wb_d;
    logic           rb_q, rb_d;
    logic [5:0]     k_q, k_d;
    logic [2:0]     r_q, r_d;
    logic           err_q, err_d;

    logic                 acc, close, hs;
    logic [5:0]           zz;
    logic [5:0]           rd_idx;
    logic signed [PW-1:0] a_ext, prod;
    logic [WIN-1:0]       sat_val;

    assign zz    = ZZ_ROM[k_q];
    assign a_ext = PW'($signed(s_tdata));

`ifdef IDCT_FEED_DEQUANT_EN
    logic [WQ-1:0]        q_q [64];
    logic [WQ-1:0]        q_d [64];
    logic signed [PW-1:0] q_ext;

    always_comb begin
        q_d = q_q;
        if (q_we) q_d[q_addr] = q_data;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 64; i++) q_q[i] <= WQ'(1);
        end else begin
            q_q <= q_d;
        end
    end

    // Table read sees the pre-write entry when a write and a beat collide.
    assign q_ext = PW'({1'b0, q_q[zz]});
    assign prod  = a_ext * q_ext;
`else
    logic unused_q;
    assign unused_q = ^{q_we, q_addr, q_data};
    assign prod     = a_ext;
`endif

    always_comb begin
        if (prod > SAT_HI)      sat_val = SAT_HI[WIN-1:0];
        else if (prod < SAT_LO) sat_val = SAT_LO[WIN-1:0];
        else                    sat_val = prod[WIN-1:0];
    end

    assign s_tready = !full_q[wb_q];
    assign m_tvalid = full_q[rb_q];
    assign m_tlast  = full_q[rb_q] && (r_q == 3'd7);
    assign err_len  = err_q;

    assign acc   = s_tvalid && s_tready;
    assign close = acc && (s_tlast || (k_q == 6'd63));
    assign hs    = m_tvalid && m_tready;

    always_comb begin
        bank_d = bank_q;
        mask_d = mask_q;
        full_d = full_q;
        wb_d   = wb_q;
        rb_d   = rb_q;
        k_d    = k_q;
        r_d    = r_q;
        err_d  = 1'b0;
        // Release and close always target different banks, so both apply.
        if (hs) begin
            if (r_q == 3'd7) begin
                full_d[rb_q] = 1'b0;
                mask_d[rb_q] = '0;
                rb_d         = ~rb_q;
                r_d          = '0;
            end else begin
                r_d = r_q + 3'd1;
            end
        end
        if (acc) begin
            bank_d[wb_q][zz] = sat_val;
            mask_d[wb_q][zz] = 1'b1;
            if (close) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
                k_d          = '0;
                err_d        = (k_q == 6'd63) != s_tlast;
            end else begin
                k_d = k_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mask_q <= '{default: '0};
            full_q <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            k_q    <= '0;
            r_q    <= '0;
            err_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            k_q    <= k_d;
            r_q    <= r_d;
            err_q  <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        bank_q <= bank_d;
    end

    // Unwritten entries of a closed block read as zero.
    always_comb begin
        m_tdata = '0;
        rd_idx  = '0;
        for (int c = 0; c < 8; c++) begin
            rd_idx = {r_q, 3'(c)};
            if (mask_q[rb_q][rd_idx])
                m_tdata[WIN*(8-c)-1 -: WIN] = bank_q[rb_q][rd_idx];
        end
    end
endmodule

// File: tb/tb_idct_dezigzag_feeder.sv
// Directed bench for idct_dezigzag_feeder: zigzag order, dequant/saturation,
// back-pressure, length errors and mid-drain reset against a small block model.
module tb_idct_dezigzag_feeder;
    localparam int WCOEF = 12;
    localparam int WQ    = 8;
    localparam int WIN   = 12;
    localparam int HI    = (2 ** (WIN - 1)) - 1;
    localparam int LO    = -(2 ** (WIN - 1));

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic [WCOEF-1:0] s_tdata = '0;
    logic             s_tvalid = 1'b0;
    logic             s_tready;
    logic             s_tlast = 1'b0;
    logic             q_we = 1'b0;
    logic [5:0]       q_addr = '0;
    logic [WQ-1:0]    q_data = '0;
    logic [WIN*8-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tready = 1'b0;
    logic             m_tlast;
    logic             err_len;

    always #5 clock = ~clock;

    idct_dezigzag_feeder #(.WCOEF(WCOEF), .WQ(WQ), .WIN(WIN)) dut (
        .clock(clock), .reset_n(reset_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .q_we(q_we), .q_addr(q_addr), .q_data(q_data),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .err_len(err_len)
    );

    int n_chk = 0;
    int n_err = 0;
    int err_pulses = 0;
    int zz[64];
    int qm[64];
    int blk[64];
    int cur[64];
    logic [WIN*8-1:0] rows_q[$];
    logic [WIN*8-1:0] exp_q[$];
    bit tl_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (m_tvalid && m_tready) begin
            rows_q.push_back(m_tdata);
            tl_q.push_back(m_tlast);
        end
        if (err_len) err_pulses++;
    end

    function automatic int sat_deq(input int v, input int q);
        int p;
`ifdef IDCT_FEED_DEQUANT_EN
        p = v * q;
`else
        p = v + 0 * q;
`endif
        if (p > HI) return HI;
        if (p < LO) return LO;
        return p;
    endfunction

    function automatic logic [WIN*8-1:0] pack_row(input int r);
        logic [WIN*8-1:0] v;
        v = '0;
        for (int c = 0; c < 8; c++) v = {v[WIN*7-1:0], WIN'(blk[r*8+c])};
        return v;
    endfunction

    task automatic send(input int v, input bit last);
        int t;
        t = 0;
        s_tdata = WCOEF'(v);
        s_tvalid = 1'b1;
        s_tlast = last;
        @(negedge clock);
        while (!s_tready && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (!s_tready) check("send timeout", 0, 1);
        @(posedge clock);
        #1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic feed_block(input int n, input bit last_end);
        for (int i = 0; i < 64; i++) blk[i] = 0;
        for (int k = 0; k < n; k++) blk[zz[k]] = sat_deq(cur[k], qm[zz[k]]);
        for (int r = 0; r < 8; r++) exp_q.push_back(pack_row(r));
        for (int k = 0; k < n; k++) send(cur[k], last_end && (k == n - 1));
    endtask

    task automatic q_write(input int a, input int v);
        q_we = 1'b1;
        q_addr = 6'(a);
        q_data = WQ'(v);
        @(posedge clock);
        #1;
        q_we = 1'b0;
        qm[a] = v;
    endtask

    task automatic check_rows(input string tag, input int n);
        int t;
        t = 0;
        while (rows_q.size() < n && t < 4000) begin
            @(posedge clock);
            t++;
        end
        #1;
        if (rows_q.size() < n) begin
            check({tag, " rows"}, rows_q.size(), n);
            return;
        end
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s row%0d", tag, i), rows_q.pop_front(), exp_q.pop_front());
            check($sformatf("%s tlast%0d", tag, i), tl_q.pop_front(), (i % 8) == 7);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int idx, e0, lo_r, hi_r;
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            lo_r = (s > 7) ? s - 7 : 0;
            hi_r = (s < 7) ? s : 7;
            if (s % 2 == 0)
                for (int r = hi_r; r >= lo_r; r--) begin zz[idx] = r * 8 + (s - r); idx++; end
            else
                for (int r = lo_r; r <= hi_r; r++) begin zz[idx] = r * 8 + (s - r); idx++; end
        end
        for (int i = 0; i < 64; i++) qm[i] = 1;

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("rst s_tready", s_tready, 1);
        check("rst m_tvalid", m_tvalid, 0);
        check("rst m_tlast", m_tlast, 0);
        check("rst err_len", err_len, 0);
        @(posedge clock);
        #1;

        // T1: ramp in zigzag order
        m_tready = 1'b1;
        e0 = err_pulses;
        for (int k = 0; k < 64; k++) cur[k] = k;
        feed_block(64, 1);
        @(negedge clock);
        check("t1 latency", m_tvalid, 1);
        check("t1 row0", m_tdata, {12'd0, 12'd1, 12'd5, 12'd6, 12'd14, 12'd15, 12'd27, 12'd28});
        check_rows("t1", 8);
        check("t1 err", err_pulses - e0, 0);

        // T2: early EOB with scaled DC
        q_write(0, 16);
        e0 = err_pulses;
        cur[0] = -5;
        cur[1] = 3;
        feed_block(2, 1);
        check_rows("t2", 8);
        check("t2 err", err_pulses - e0, 1);

        // T3: saturation at both ends
        q_write(0, 255);
        e0 = err_pulses;
        cur[0] = 2047;
        feed_block(1, 1);
        cur[0] = -2048;
        feed_block(1, 1);
        check_rows("t3", 16);
        check("t3 err", err_pulses - e0, 2);
        q_write(0, 1);

        // T4: back-pressure across three blocks
        m_tready = 1'b0;
        e0 = err_pulses;
        for (int k = 0; k < 64; k++) cur[k] = k - 100;
        feed_block(64, 1);
        for (int k = 0; k < 64; k++) cur[k] = 64 + k - 100;
        feed_block(64, 1);
        @(negedge clock);
        check("t4 s_tready low", s_tready, 0);
        check("t4 held row0", m_tdata, exp_q[0]);
        repeat (3) @(negedge clock);
        check("t4 still low", s_tready, 0);
        check("t4 still held", m_tdata, exp_q[0]);
        @(posedge clock);
        #1;
        for (int k = 0; k < 64; k++) cur[k] = 128 + k - 100;
        fork
            feed_block(64, 1);
            begin
                repeat (10) @(posedge clock);
                #1 m_tready = 1'b1;
            end
        join
        check_rows("t4", 24);
        check("t4 err", err_pulses - e0, 0);

        // T5: 64 beats without s_tlast, then a 1-beat block
        e0 = err_pulses;
        for (int k = 0; k < 64; k++) cur[k] = 1000 - 31 * k;
        feed_block(64, 0);
        cur[0] = 7;
        feed_block(1, 1);
        check_rows("t5", 16);
        check("t5 err", err_pulses - e0, 2);

        // T6: reset in the middle of a drain
        q_write(9, 3);
        m_tready = 1'b0;
        for (int k = 0; k < 64; k++) cur[k] = 2 * k - 50;
        feed_block(64, 1);
        m_tready = 1'b1;
        repeat (3) @(posedge clock);
        #1 m_tready = 1'b0;
        @(negedge clock);
        check("t6 row3 before rst", m_tdata, exp_q[3]);
        @(posedge clock);
        #1 reset_n = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        check("t6 m_tvalid", m_tvalid, 0);
        check("t6 s_tready", s_tready, 1);
        check("t6 m_tlast", m_tlast, 0);
        @(posedge clock);
        #1;
        rows_q.delete();
        tl_q.delete();
        exp_q.delete();
        for (int i = 0; i < 64; i++) qm[i] = 1;
        m_tready = 1'b1;
        e0 = err_pulses;
        for (int k = 0; k < 6; k++) cur[k] = 10 + k;
        feed_block(6, 1);
        check_rows("t6", 8);
        check("t6 err", err_pulses - e0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
